blink_meter: RTL and testbench
==============================

// Module: blink_meter
// PURPOSE
//   Measures a periodic on/off input (a blink or cursor-flash line) and reports
//   the high and low durations of each full period, in clk cycles.
//   Used on the board to check blink timebases against their parameters and to
//   drive period/duty readouts on the VGA debug overlay.
//   Flags an input stuck high or low longer than TIMEOUT cycles.
// PARAMETERS
//   COUNTER_WIDTH  27           width of duration counters and outputs
//   TIMEOUT        100_000_000  cycles at one level before stuck is flagged;
//                               legal range 2 .. 2**COUNTER_WIDTH-1
//   SYNC_STAGES    2            flip-flops in the input synchroniser (>=2)
// PORTS
//   clk            in   1      system clock
//   reset_n        in   1      asynchronous, active-low reset
//   signal_in      in   1      asynchronous on/off signal being measured
//   on_duration    out  CW     high cycles of the last complete period
//   off_duration   out  CW     low cycles of the last complete period
//   measure_valid  out  1      one-cycle pulse when both durations are updated
//   stuck          out  1      level: input held at one level >= TIMEOUT cycles
//   stuck_level    out  1      level of the input when stuck was raised
// BEHAVIOUR
//   Reset (reset_n=0, async): all outputs 0, state SEARCH, counter 0,
//     synchroniser and edge history 0.
//   Input path: SYNC_STAGES-FF synchroniser gives s; prev is s delayed 1 clk;
//     rise = s & ~prev, fall = ~s & prev. There is no glitch filter.
//   States:
//     SEARCH: wait for rise. On rise: counter<=1, go HIGH. No duration output.
//     HIGH: if fall: on_duration<=counter, counter<=1, go LOW.
//           else counter<=counter+1.
//     LOW:  if rise: off_duration<=counter, measure_valid<=1, stuck<=0,
//           counter<=1, go HIGH. else counter<=counter+1.
//   Timeout: in HIGH or LOW with no edge this cycle and counter==TIMEOUT:
//     stuck<=1, stuck_level<=s, counter<=0, go SEARCH.
//     on_duration and off_duration keep their values.
//     An edge in the same cycle takes priority over the timeout.
//   Count semantics: durations are exact synchronised-level cycle counts.
//     counter never exceeds TIMEOUT, so it cannot wrap.
//   Period semantics: a period runs from one rise to the next rise.
//     on_duration is registered at the fall.
//     off_duration is registered together with measure_valid, at the closing rise.
//     Between a fall and the next valid pulse, on_duration already holds the new
//     high time while off_duration still holds the previous period's value.
//   Latency: measure_valid is high in the clk cycle after the internal rise
//     that closes the period. That is SYNC_STAGES+1 clk cycles after the
//     signal_in edge, when signal_in meets setup and hold.
//   First period after reset or after a timeout: the first rise only arms the
//     meter. The first measure_valid comes at the second rise.
//   measure_valid is never high in two consecutive cycles; minimum spacing is 2.
//   stuck stays set through SEARCH. It is cleared only by the next
//     measure_valid, in the same cycle.
//   A 1-cycle high pulse gives on_duration=1. A 1-cycle low gap gives
//     off_duration=1.
// TESTING (CW=8, TIMEOUT=20, SYNC_STAGES=2)
//   1. Reset, then signal_in periodic high 5 / low 3 clks
//      -> no valid for the first period, then valid once per 8 clks
//         with on=5, off=3.
//   2. Duty change mid-run, high 5/low 3 -> high 2/low 9
//      -> on=2 reported after its fall. At the next rise: off=9 with valid.
//         No mixed values at the valid pulses.
//   3. Input held low 25 clks after a fall
//      -> stuck=1, stuck_level=0 when LOW counter hits 20. Durations unchanged.
//         Then restart pattern: stuck clears at the second rise, with valid.
//   4. Input held high 25 clks
//      -> stuck=1, stuck_level=1, no valid.
//   5. High 1 / low 1 pattern
//      -> on=1, off=1, valid every 2 clks, never 2 cycles back-to-back.
//   6. Assert reset_n=0 mid-HIGH, asynchronously between edges
//      -> all outputs 0 immediately. After release, the first valid comes only
//         after two rises.

Source files
------------

// File: rtl/blink_meter.sv
// blink_meter: measures the high and low durations of each full period of an
// asynchronous on/off line, in clk cycles, and flags a line stuck at one level.
module blink_meter #(
  parameter int unsigned COUNTER_WIDTH = 27,
  parameter int unsigned TIMEOUT       = 100_000_000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     signal_in,
  output logic [COUNTER_WIDTH-1:0] on_duration,
  output logic [COUNTER_WIDTH-1:0] off_duration,
  output logic                     measure_valid,
  output logic                     stuck,
  output logic                     stuck_level
);

  typedef enum logic [1:0] {
    StSearch,
    StHigh,
    StLow
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] TimeoutVal = COUNTER_WIDTH'(TIMEOUT);
  localparam logic [COUNTER_WIDTH-1:0] CountOne   = COUNTER_WIDTH'(1);

  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     prev_q;
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [COUNTER_WIDTH-1:0] on_q, on_d;
  logic [COUNTER_WIDTH-1:0] off_q, off_d;
  logic                     valid_q, valid_d;
  logic                     stuck_q, stuck_d;
  logic                     level_q, level_d;

  logic s;
  logic rise;
  logic fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // State register, synchroniser and edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      state_q <= StSearch;
      count_q <= '0;
      on_q    <= '0;
      off_q   <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= s;
      state_q <= state_d;
      count_q <= count_d;
      on_q    <= on_d;
      off_q   <= off_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      level_q <= level_d;
    end
  end

  // Next-state: period measurement FSM with stuck-level timeout
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], signal_in};
    state_d = state_q;
    count_d = count_q;
    on_d    = on_q;
    off_d   = off_q;
    valid_d = 1'b0;
    stuck_d = stuck_q;
    level_d = level_q;

    case (state_q)
      StSearch: begin
        // First rise only arms the meter; no duration is reported
        if (rise) begin
          count_d = CountOne;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (fall) begin
          on_d    = count_q;
          count_d = CountOne;
          state_d = StLow;
        end else if (count_q == TimeoutVal) begin
          stuck_d = 1'b1;
          level_d = s;
          count_d = '0;
          state_d = StSearch;
        end else begin
          count_d = count_q + CountOne;
        end
      end
      StLow: begin
        if (rise) begin
          off_d   = count_q;
          valid_d = 1'b1;
          stuck_d = 1'b0;
          count_d = CountOne;
          state_d = StHigh;
        end else if (count_q == TimeoutVal) begin
          stuck_d = 1'b1;
          level_d = s;
          count_d = '0;
          state_d = StSearch;
        end else begin
          count_d = count_q + CountOne;
        end
      end
      default: begin
        state_d = StSearch;
        count_d = '0;
      end
    endcase
  end

  assign on_duration   = on_q;
  assign off_duration  = off_q;
  assign measure_valid = valid_q;
  assign stuck         = stuck_q;
  assign stuck_level   = level_q;

endmodule

// File: tb/tb_blink_meter.sv
// tb_blink_meter: directed bench for blink_meter (CW=8, TIMEOUT=20, 2 sync stages).
module tb_blink_meter;

  localparam int unsigned Cw = 8;

  logic          clk;
  logic          reset_n;
  logic          signal_in;
  logic [Cw-1:0] on_duration;
  logic [Cw-1:0] off_duration;
  logic          measure_valid;
  logic          stuck;
  logic          stuck_level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [Cw-1:0] cap_on[$];
  logic [Cw-1:0] cap_off[$];
  logic          cap_stuck[$];
  logic          prev_valid = 1'b0;

  blink_meter #(
    .COUNTER_WIDTH(Cw),
    .TIMEOUT      (20),
    .SYNC_STAGES  (2)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .signal_in    (signal_in),
    .on_duration  (on_duration),
    .off_duration (off_duration),
    .measure_valid(measure_valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Record every valid pulse and reject back-to-back pulses
  always @(negedge clk) begin
    if (measure_valid === 1'b1) begin
      check("valid_spacing", {31'd0, prev_valid}, 32'd0);
      cap_on.push_back(on_duration);
      cap_off.push_back(off_duration);
      cap_stuck.push_back(stuck);
    end
    prev_valid = measure_valid;
  end

  // Hold signal_in at lvl for n clock edges; returns just after a posedge
  task automatic drive(input logic lvl, input int n);
    signal_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_pulse(input string tag, input logic [Cw-1:0] on, input logic [Cw-1:0] off);
    if (cap_on.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_on"}, 32'(cap_on.pop_front()), 32'(on));
      check({tag, "_off"}, 32'(cap_off.pop_front()), 32'(off));
      check({tag, "_stuck"}, 32'(cap_stuck.pop_front()), 32'd0);
    end
  endtask

  task automatic no_more(input string tag);
    check({tag, "_extra"}, 32'(cap_on.size()), 32'd0);
    cap_on.delete();
    cap_off.delete();
    cap_stuck.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_on"}, 32'(on_duration), 32'd0);
    check({tag, "_off"}, 32'(off_duration), 32'd0);
    check({tag, "_valid"}, 32'(measure_valid), 32'd0);
    check({tag, "_stuck"}, 32'(stuck), 32'd0);
    check({tag, "_level"}, 32'(stuck_level), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    signal_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    drive(1'b0, 3);

    // 1: high 5 / low 3; first rise arms, later rises report
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 3);
    end
    for (int i = 0; i < 3; i++) pop_pulse("p1", 8'd5, 8'd3);
    no_more("p1");

    // 2: duty change to high 2 / low 9
    drive(1'b1, 2);
    drive(1'b0, 5);
    check("p2_mid_on", 32'(on_duration), 32'd2);
    check("p2_mid_off", 32'(off_duration), 32'd3);
    drive(1'b0, 4);
    drive(1'b1, 2);
    drive(1'b0, 9);
    pop_pulse("p2a", 8'd5, 8'd3);
    pop_pulse("p2b", 8'd2, 8'd9);
    no_more("p2");

    // 3: held low after a fall, then restart
    drive(1'b1, 5);
    drive(1'b0, 22);
    check("p3_pre_stuck", 32'(stuck), 32'd0);
    drive(1'b0, 1);
    check("p3_stuck", 32'(stuck), 32'd1);
    check("p3_level", 32'(stuck_level), 32'd0);
    check("p3_on_kept", 32'(on_duration), 32'd5);
    check("p3_off_kept", 32'(off_duration), 32'd9);
    drive(1'b0, 2);
    pop_pulse("p3", 8'd2, 8'd9);
    no_more("p3");
    drive(1'b1, 3);
    drive(1'b0, 4);
    check("p3_armed_stuck", 32'(stuck), 32'd1);
    no_more("p3_armed");
    drive(1'b1, 3);
    drive(1'b0, 4);

    // 4: held high
    drive(1'b1, 25);
    pop_pulse("p4a", 8'd3, 8'd4);
    pop_pulse("p4b", 8'd3, 8'd4);
    no_more("p4");
    check("p4_stuck", 32'(stuck), 32'd1);
    check("p4_level", 32'(stuck_level), 32'd1);
    check("p4_on_kept", 32'(on_duration), 32'd3);
    check("p4_off_kept", 32'(off_duration), 32'd4);

    // 5: high 1 / low 1
    drive(1'b0, 3);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 4);
    for (int i = 0; i < 5; i++) pop_pulse("p5", 8'd1, 8'd1);
    no_more("p5");
    check("p5_stuck_cleared", 32'(stuck), 32'd0);

    // 6: asynchronous reset mid-HIGH
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 3);
    signal_in = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("p6_pre_on", 32'(on_duration), 32'd5);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("p6_async");
    pop_pulse("p6a", 8'd1, 8'd5);
    pop_pulse("p6b", 8'd5, 8'd3);
    pop_pulse("p6c", 8'd5, 8'd3);
    no_more("p6_pre");
    signal_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 2);
    drive(1'b1, 5);
    drive(1'b0, 3);
    no_more("p6_armed");
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 2);
    drive(1'b0, 3);
    pop_pulse("p6d", 8'd5, 8'd3);
    pop_pulse("p6e", 8'd5, 8'd3);
    no_more("p6_post");
    check("p6_on_last", 32'(on_duration), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
